// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling engine: the controller state
// encoding and the helper that locates one key element inside the packed key.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INIT   = 4'd1,
    ST_RD_I   = 4'd2,
    ST_WAIT_I = 4'd3,
    ST_RD_J   = 4'd4,
    ST_WAIT_J = 4'd5,
    ST_WR_I   = 4'd6,
    ST_WR_J   = 4'd7,
    ST_DONE   = 4'd8
  } rc4_state_e;

  // Bit offset of key element 'elem' in a key of 'key_bytes' elements of
  // 'width' bits each. Element 0 sits in the most-significant slot.
  function automatic int unsigned key_offset(input int unsigned elem,
                                             input int unsigned key_bytes,
                                             input int unsigned width);
    return (key_bytes - 1 - elem) * width;
  endfunction

endpackage

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine. Drives an external synchronous S-RAM: first fills
// it with the identity permutation, then performs the KSA shuffle using a
// read-read-write-write sequence of six cycles per index.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [KEY_BYTES*ADDR_W-1:0]   key,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [ADDR_W-1:0]             s_wrdata,
  output logic                          s_wren,
  input  logic [ADDR_W-1:0]             s_rddata
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [KIDX_W-1:0] KIDX_ONE  = KIDX_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};

  rc4_state_e                    state;
  logic [ADDR_W-1:0]             i;
  logic [ADDR_W-1:0]             j;
  logic [ADDR_W-1:0]             si;
  logic [ADDR_W-1:0]             sj;
  logic [KEY_BYTES*ADDR_W-1:0]   key_reg;
  logic [KIDX_W-1:0]             kidx;
  logic [ADDR_W-1:0]             key_elem;

  // Select the key element for the current index; kidx tracks i mod KEY_BYTES
  // so no divider is needed, and with a single element it always picks 0.
  always_comb begin
    key_elem = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KIDX_W'(k)) begin
        key_elem = key_reg[key_offset(k, KEY_BYTES, ADDR_W) +: ADDR_W];
      end
    end
  end

  // Controller: init fill, six-cycle shuffle per index, then a one-cycle
  // DONE that can chain straight into a new run when start is still high.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      key_reg <= '0;
      kidx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_reg <= key;
            i       <= '0;
            j       <= '0;
            state   <= ST_INIT;
          end
        end
        ST_INIT: begin
          i <= i + IDX_ONE;
          if (i == IDX_LAST) begin
            j     <= '0;
            kidx  <= '0;
            state <= ST_RD_I;
          end
        end
        ST_RD_I: begin
          state <= ST_WAIT_I;
        end
        ST_WAIT_I: begin
          si    <= s_rddata;
          j     <= j + s_rddata + key_elem;
          state <= ST_RD_J;
        end
        ST_RD_J: begin
          state <= ST_WAIT_J;
        end
        ST_WAIT_J: begin
          sj    <= s_rddata;
          state <= ST_WR_I;
        end
        ST_WR_I: begin
          state <= ST_WR_J;
        end
        ST_WR_J: begin
          kidx <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_ONE;
          i    <= i + IDX_ONE;
          if (i == IDX_LAST) begin
            state <= ST_DONE;
          end else begin
            state <= ST_RD_I;
          end
        end
        ST_DONE: begin
          if (start) begin
            key_reg <= key;
            i       <= '0;
            j       <= '0;
            state   <= ST_INIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags decoded from the state so reset clears them immediately.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_INIT, ST_RD_I, ST_WAIT_I, ST_RD_J,
      ST_WAIT_J, ST_WR_I, ST_WR_J: busy = 1'b1;
      ST_DONE:                     done = 1'b1;
      default: ;
    endcase
  end

  // RAM port decode; address and data are held at zero whenever no access
  // is being made so the bus is quiet between operations.
  always_comb begin
    s_wren   = 1'b0;
    s_addr   = '0;
    s_wrdata = '0;
    case (state)
      ST_INIT: begin
        s_wren   = 1'b1;
        s_addr   = i;
        s_wrdata = i;
      end
      ST_RD_I: begin
        s_addr = i;
      end
      ST_RD_J: begin
        s_addr = j;
      end
      ST_WR_I: begin
        s_wren   = 1'b1;
        s_addr   = i;
        s_wrdata = sj;
      end
      ST_WR_J: begin
        s_wren   = 1'b1;
        s_addr   = j;
        s_wrdata = si;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Directed bench for rc4_ksa_engine: three engine instances (4-entry, 256-entry
// with 3-byte key, 256-entry with 1-byte key), each with its own behavioural
// synchronous RAM, exercised one after another from a single sequence.
module tb_rc4_ksa_engine;

  logic clk;
  logic reset_n;

  // Small instance: ADDR_W=2, KEY_BYTES=1
  logic       start_s, busy_s, done_s, wren_s;
  logic [1:0] key_s, addr_s, wrdata_s, rd_s;
  logic [1:0] mem_s [4];

  // Big instance: ADDR_W=8, KEY_BYTES=3
  logic        start_b, busy_b, done_b, wren_b;
  logic [23:0] key_b;
  logic [7:0]  addr_b, wrdata_b, rd_b;
  logic [7:0]  mem_b [256];

  // One-byte-key instance: ADDR_W=8, KEY_BYTES=1
  logic       start_o, busy_o, done_o, wren_o;
  logic [7:0] key_o, addr_o, wrdata_o, rd_o;
  logic [7:0] mem_o [256];

  int sel;
  logic cur_busy, cur_done;
  int errors;
  int checks;
  int exp_s [256];
  int exp_small [4];

  rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(1)) u_small (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start_s), .key(key_s),
    .busy(busy_s), .done(done_s), .s_addr(addr_s), .s_wrdata(wrdata_s),
    .s_wren(wren_s), .s_rddata(rd_s)
  );

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) u_big (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start_b), .key(key_b),
    .busy(busy_b), .done(done_b), .s_addr(addr_b), .s_wrdata(wrdata_b),
    .s_wren(wren_b), .s_rddata(rd_b)
  );

  rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(1)) u_one (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start_o), .key(key_o),
    .busy(busy_o), .done(done_o), .s_addr(addr_o), .s_wrdata(wrdata_o),
    .s_wren(wren_o), .s_rddata(rd_o)
  );

  // 50 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural synchronous RAMs with one cycle of read latency
  always @(posedge clk) begin
    rd_s <= mem_s[addr_s];
    if (wren_s) mem_s[addr_s] <= wrdata_s;
  end

  always @(posedge clk) begin
    rd_b <= mem_b[addr_b];
    if (wren_b) mem_b[addr_b] <= wrdata_b;
  end

  always @(posedge clk) begin
    rd_o <= mem_o[addr_o];
    if (wren_o) mem_o[addr_o] <= wrdata_o;
  end

  // Status of whichever instance is currently under test
  always_comb begin
    cur_busy = 1'b0;
    cur_done = 1'b0;
    case (sel)
      0: begin cur_busy = busy_s; cur_done = done_s; end
      1: begin cur_busy = busy_b; cur_done = done_b; end
      default: begin cur_busy = busy_o; cur_done = done_o; end
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    case (sel)
      0: start_s = v;
      1: start_b = v;
      default: start_o = v;
    endcase
  endtask

  task automatic set_key(input logic [23:0] k);
    case (sel)
      0: key_s = k[1:0];
      1: key_b = k;
      default: key_o = k[7:0];
    endcase
  endtask

  // Reference RC4 KSA over 8-bit elements
  task automatic build_model(input int nkey, input logic [23:0] kb);
    int jj;
    int t;
    int ke;
    logic [23:0] sh;
    jj = 0;
    for (int k = 0; k < 256; k++) exp_s[k] = k;
    for (int k = 0; k < 256; k++) begin
      sh = kb >> ((nkey - 1 - (k % nkey)) * 8);
      ke = int'(sh[7:0]);
      jj = (jj + exp_s[k] + ke) % 256;
      t = exp_s[k];
      exp_s[k] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic compare_ram(input string tag);
    int mism;
    logic [7:0] v;
    mism = 0;
    for (int k = 0; k < 256; k++) begin
      v = (sel == 1) ? mem_b[k] : mem_o[k];
      if (v !== 8'(exp_s[k])) mism++;
    end
    check_output(tag, mism, 0);
  endtask

  // Pulse start with a key and count negedges until done (bounded)
  task automatic apply_stimulus(input logic [23:0] k, output int done_at, output int busy_cnt);
    @(negedge clk);
    set_key(k);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    done_at = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      if (cur_busy) busy_cnt++;
      if (cur_done) begin
        done_at = n;
        break;
      end
    end
  endtask

  // Directed sequence
  initial begin
    int done_at;
    int busy_cnt;
    int d1;
    int d2;
    errors = 0;
    checks = 0;
    sel = 0;
    exp_small = '{0, 2, 3, 1};
    start_s = 1'b0; start_b = 1'b0; start_o = 1'b0;
    key_s = '0; key_b = '0; key_o = '0;
    reset_n = 1'b0;

    #3;
    check_output("reset_busy", {31'd0, busy_b}, 0);
    check_output("reset_done", {31'd0, done_b}, 0);
    check_output("reset_wren", {31'd0, wren_b}, 0);
    check_output("reset_addr", {24'd0, addr_b}, 0);
    check_output("reset_wrdata", {24'd0, wrdata_b}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Small array, key=1: hand-derived permutation [0,2,3,1]
    sel = 0;
    apply_stimulus(24'd1, done_at, busy_cnt);
    check_output("small_done_cycle", done_at, 29);
    check_output("small_busy_cycles", busy_cnt, 28);
    check_output("small_busy_in_done", {31'd0, busy_s}, 0);
    for (int k = 0; k < 4; k++) check_output("small_S", {30'd0, mem_s[k]}, exp_small[k]);
    @(negedge clk);
    check_output("small_done_one_cycle", {31'd0, done_s}, 0);

    // Full array, 3-byte key 0x000249
    sel = 1;
    build_model(3, 24'h000249);
    apply_stimulus(24'h000249, done_at, busy_cnt);
    check_output("big_done_cycle", done_at, 1793);
    check_output("big_busy_cycles", busy_cnt, 1792);
    compare_ram("big_S_vs_model");

    // Full array, 1-byte zero key; i==j at i=0 must leave S[0]=0
    sel = 2;
    build_model(1, 24'h000000);
    @(negedge clk);
    set_key(24'h0);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    repeat (262) @(posedge clk);
    #1;
    check_output("one_S0_after_iter0", {24'd0, mem_o[0]}, 0);
    done_at = 0;
    for (int n = 263; n <= 4000; n++) begin
      @(negedge clk);
      if (cur_done) begin
        done_at = n;
        break;
      end
    end
    check_output("one_done_cycle", done_at, 1793);
    compare_ram("one_S_vs_model");

    // Reset mid-shuffle, then a fresh run with another key
    sel = 1;
    @(negedge clk);
    set_key(24'h000249);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    repeat (599) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_output("midreset_busy", {31'd0, busy_b}, 0);
    check_output("midreset_wren", {31'd0, wren_b}, 0);
    check_output("midreset_done", {31'd0, done_b}, 0);
    check_output("midreset_addr", {24'd0, addr_b}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    build_model(3, 24'h1f2e3d);
    apply_stimulus(24'h1f2e3d, done_at, busy_cnt);
    check_output("after_reset_done_cycle", done_at, 1793);
    compare_ram("after_reset_S_vs_model");

    // Second start and key change while busy are ignored
    build_model(3, 24'h010203);
    @(negedge clk);
    set_key(24'h010203);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    repeat (100) @(posedge clk);
    #1 set_key(24'hffffff);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
    done_at = 0;
    for (int n = 102; n <= 4000; n++) begin
      @(negedge clk);
      if (cur_done) begin
        done_at = n;
        break;
      end
    end
    check_output("ignore_start_done_cycle", done_at, 1793);
    compare_ram("ignore_start_S_vs_model");

    // Start held high: back-to-back runs with only the DONE cycle between
    build_model(3, 24'h000249);
    @(negedge clk);
    set_key(24'h000249);
    set_start(1'b1);
    d1 = 0;
    d2 = 0;
    for (int n = 1; n <= 8000; n++) begin
      @(negedge clk);
      if (cur_done && d1 == 0) begin
        d1 = n;
      end else if (d1 != 0 && n == d1 + 1) begin
        check_output("hold_no_idle_gap", {31'd0, busy_b}, 1);
        set_start(1'b0);
      end else if (cur_done && d1 != 0) begin
        d2 = n;
        break;
      end
    end
    check_output("hold_done_spacing", d2 - d1, 1793);
    compare_ram("hold_S_vs_model");
    @(negedge clk);
    check_output("hold_returns_idle", {31'd0, busy_b}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
